keypad_scan_encoder: RTL and testbench
======================================

Name: keypad_scan_encoder

Overview:
- Drives a 4x4 matrix keypad and scans it one column at a time.
- Debounces the key press and the key release.
- Outputs the key as an 8-bit code with a clean `pressed` level. This is the transmit side of the key interface consumed by the calculator FSM, which latches `key_code` on the rising edge of `pressed` and advances state on its falling edge.
- `key_code` must be stable around both edges of `pressed`.

Parameters:
- SCAN_DIV, 1000: clk cycles per column dwell. One "tick" is the last cycle of a dwell. Legal range is ≥ 2.
- DEBOUNCE_CNT, 8: number of consecutive consistent ticks required to accept a press or a release. Legal range is ≥ 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- row  in  4  keypad rows, pulled up; a pressed key pulls its row low
- col  out  4  column drive, active-low, exactly one bit low at any time
- key_code  out  8  encoded key; 8'hFF when no key is pressed
- pressed  out  1  high while a debounced key is held
- key_valid  out  1  one-clk pulse in the same cycle that `pressed` rises

Behaviour:
- Reset: rst low asynchronously forces all of the following, regardless of state or operation in progress:
  - col = 4'b1110, key_code = 8'hFF, pressed = 0, key_valid = 0
  - all counters = 0, state = SCAN
- Input synchronisation: row passes through a 2-FF synchronizer. All decisions use the synchronized value (rs), sampled at ticks only.
- Key map by (row, col), with codes:
  - r0: 1 (8'h01), 2 (8'h02), 3 (8'h03), + (8'hF0)
  - r1: 4 (8'h04), 5 (8'h05), 6 (8'h06), - (8'hF1)
  - r2: 7 (8'h07), 8 (8'h08), 9 (8'h09), * (8'hF2)
  - r3: Clear (8'hC0), 0 (8'h00), = (8'hE0), / (8'hF3)
  - Code classes: digits have bit7 = 0; operators have [7:4] = 4'hF; Clear is 8'hC0; Equals is 8'hE0.
- Multiple rows low: the lowest row index wins. Multiple keys in different columns are resolved by whichever column is scanned first.
- SCAN state:
  - col rotates 1110 → 1101 → 1011 → 0111 → 1110 (wraps), advancing once per SCAN_DIV clocks.
  - At a tick with rs != 4'hF: latch the winning row and the current col, freeze col, clear the debounce counter, go to DEBOUNCE.
- DEBOUNCE state:
  - Each tick with the latched row still low increments the counter. Any other tick (row high or a different row winning) returns to SCAN; col resumes rotating from the frozen column.
  - When the counter reaches DEBOUNCE_CNT: key_code ← the mapped code.
  - One clk later: pressed ← 1, key_valid = 1 for that single cycle, state = HELD.
  - This guarantees key_code is setup 1 clk before the rising edge of pressed.
- HELD state:
  - col stays frozen.
  - Ticks with the latched row high increment the release counter; a tick with the row low clears it.
  - At DEBOUNCE_CNT: pressed ← 0, go to RELEASE.
- RELEASE state:
  - key_code holds for SCAN_DIV clks after pressed falls, then becomes 8'hFF.
  - Then go to SCAN with col advancing to the next column.
- Auto-repeat: none. A held key produces exactly one pressed pulse.
- Rollover: none. A second key pressed while in HELD is ignored. Only the latched row/column releases the key.
- Latency: from the first tick seeing the press, key_code is set DEBOUNCE_CNT ticks later and pressed rises 1 clk after that.
- A glitch shorter than DEBOUNCE_CNT ticks on press or release produces no output change.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset release, no keys: col cycles 1110, 1101, 1011, 0111, 1110 every 4 clks → key_code = FF, pressed = 0 throughout.
- Hold key "5" (row1 low while col = 1101) for 40 clks, then release:
  - key_code = 8'h05 exactly 3 ticks after detection.
  - pressed = 1 the next clk, key_valid pulses once.
  - After release, pressed falls after 3 high ticks.
  - key_code = 05 for 4 more clks, then FF.
- Press "=" (row3, col 1011) with a 1-tick bounce (low, high, low, low, low) → no output from the first contact; code E0 asserted after the stable run.
  - Repeat with "+" → F0, and with Clear → C0.
- Press "1" then, while held, press "9" → only 8'h01 is produced.
  - Releasing "1" while "9" is still held → pressed falls. A new press for "9" (8'h09) follows after the scan resumes.
- Rows 0 and 2 both low on col 1110 → code 8'h01 (lowest row wins).
- Assert rst low while in HELD with pressed = 1 → pressed = 0, key_code = FF, col = 1110 immediately (asynchronously, without waiting for clk).
  - After rst returns high with the key still held, a fresh debounce is required before pressed asserts again.

Source files
------------

// File: rtl/keypad_scan_encoder_if.sv
// ============================================================================
//  Module      : keypad_scan_encoder_if
//  Description : Keypad-side signal bundle for the scan encoder. The master
//                view belongs to the encoder: it drives the column lines and
//                the key outputs, and it reads the row lines. The slave view
//                belongs to the keypad and its consumer.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface keypad_scan_encoder_if;
    logic [3:0] row;        // keypad rows, pulled up, low = key closed
    logic [3:0] col;        // active-low column drive
    logic [7:0] key_code;   // encoded key, 8'hFF when idle
    logic       pressed;    // debounced key-held level
    logic       key_valid;  // one-cycle pulse with the rising edge of pressed

    modport master (
        input  row,
        output col,
        output key_code,
        output pressed,
        output key_valid
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  pressed,
        input  key_valid
    );
endinterface

`default_nettype wire

// File: rtl/keypad_scan_encoder.sv
// ============================================================================
//  Module      : keypad_scan_encoder
//  Description : 4x4 matrix keypad scanner. Rotates a single low column,
//                samples the synchronised rows once per column dwell,
//                debounces both press and release, and presents an 8-bit key
//                code together with a clean pressed level. key_code is loaded
//                one clock before pressed rises, is held while pressed is high,
//                and is held for one further dwell after pressed falls.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module keypad_scan_encoder #(
    parameter int SCAN_DIV     = 1000,  // clocks per column dwell, >= 2
    parameter int DEBOUNCE_CNT = 8      // consistent ticks to accept, >= 1
) (
    input  logic                  clk,
    input  logic                  rst,  // asynchronous, active low
    keypad_scan_encoder_if.master kp
);

    localparam int               DIV_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam int               CNT_W     = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       CODE_NONE = 8'hFF;

    typedef enum logic [2:0] {
        S_SCAN     = 3'd0,  // rotating columns, looking for any low row
        S_DEBOUNCE = 3'd1,  // column frozen, counting consistent press ticks
        S_PRESS    = 3'd2,  // key_code already loaded, raise pressed now
        S_HELD     = 3'd3,  // key accepted, counting consistent release ticks
        S_RELEASE  = 3'd4   // pressed low, key_code kept for one more dwell
    } state_t;

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    state_t           state_q,     state_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [3:0]       rs_meta_q;
    logic [3:0]       rs_q;
    logic [1:0]       col_idx_q,   col_idx_d;
    logic [1:0]       row_idx_q,   row_idx_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [7:0]       key_code_q,  key_code_d;
    logic             pressed_q,   pressed_d;
    logic             key_valid_q, key_valid_d;

    logic             w_tick;
    logic             w_row_hit;
    logic [1:0]       w_row_idx;
    logic [CNT_W-1:0] w_cnt_inc;

    // Key map indexed by (row, column); column 0 is the one driven by 4'b1110.
    function automatic logic [7:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [7:0] code;
        case ({r, c})
            4'h0:    code = 8'h01;
            4'h1:    code = 8'h02;
            4'h2:    code = 8'h03;
            4'h3:    code = 8'hF0;  // +
            4'h4:    code = 8'h04;
            4'h5:    code = 8'h05;
            4'h6:    code = 8'h06;
            4'h7:    code = 8'hF1;  // -
            4'h8:    code = 8'h07;
            4'h9:    code = 8'h08;
            4'hA:    code = 8'h09;
            4'hB:    code = 8'hF2;  // *
            4'hC:    code = 8'hC0;  // Clear
            4'hD:    code = 8'h00;
            4'hE:    code = 8'hE0;  // =
            default: code = 8'hF3;  // /
        endcase
        return code;
    endfunction

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
        end else begin
            rs_meta_q <= kp.row;
            rs_q      <= rs_meta_q;
        end
    end

    // Free-running dwell divider; the last cycle of every dwell is a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign w_tick = (div_q == DIV_LAST);
    assign div_d  = w_tick ? '0 : div_q + DIV_W'(1);

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        w_row_hit = (rs_q != 4'hF);
        w_row_idx = 2'd0;
        if (!rs_q[0]) begin
            w_row_idx = 2'd0;
        end else if (!rs_q[1]) begin
            w_row_idx = 2'd1;
        end else if (!rs_q[2]) begin
            w_row_idx = 2'd2;
        end else if (!rs_q[3]) begin
            w_row_idx = 2'd3;
        end
    end

    assign w_cnt_inc = cnt_q + CNT_ONE;

    // Scan/debounce state machine: next state, counters and output values.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        pressed_d   = pressed_q;
        key_valid_d = 1'b0;

        case (state_q)
            S_SCAN: begin
                if (w_tick) begin
                    if (w_row_hit) begin
                        // Column stays where it is; it identifies the key.
                        row_idx_d = w_row_idx;
                        cnt_d     = '0;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end

            S_DEBOUNCE: begin
                if (w_tick) begin
                    if (w_row_hit && (w_row_idx == row_idx_q)) begin
                        if (w_cnt_inc == CNT_LAST) begin
                            // Code goes out first so it is stable one clock
                            // before the consumer sees pressed rise.
                            cnt_d      = '0;
                            key_code_d = map_key(row_idx_q, col_idx_q);
                            state_d    = S_PRESS;
                        end else begin
                            cnt_d = w_cnt_inc;
                        end
                    end else begin
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = S_SCAN;
                    end
                end
            end

            S_PRESS: begin
                pressed_d   = 1'b1;
                key_valid_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_HELD;
            end

            S_HELD: begin
                if (w_tick) begin
                    // Only the latched row counts; other keys are ignored.
                    if (rs_q[row_idx_q]) begin
                        if (w_cnt_inc == CNT_LAST) begin
                            cnt_d     = '0;
                            pressed_d = 1'b0;
                            state_d   = S_RELEASE;
                        end else begin
                            cnt_d = w_cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end

            S_RELEASE: begin
                // pressed fell on a tick, so the next tick is one dwell later.
                if (w_tick) begin
                    key_code_d = CODE_NONE;
                    col_idx_d  = col_idx_q + 2'd1;
                    state_d    = S_SCAN;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_SCAN;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            cnt_q       <= '0;
            key_code_q  <= CODE_NONE;
            pressed_q   <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            pressed_q   <= pressed_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign kp.col       = ~(4'b0001 << col_idx_q);
    assign kp.key_code  = key_code_q;
    assign kp.pressed   = pressed_q;
    assign kp.key_valid = key_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_encoder.sv
// ============================================================================
//  Module      : tb_keypad_scan_encoder
//  Description : Self-checking bench for keypad_scan_encoder. A keypad model
//                turns a set of closed keys into row levels from the driven
//                column. Directed sequences cover reset, idle scanning, exact
//                press/release latency, bounce, rollover, multi-row priority
//                and reset while held; random presses and glitches follow.
//                A scoreboard of expected key codes is consumed at each
//                rising edge of pressed.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_scan_encoder;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    // Key codes indexed by row*4 + column.
    localparam logic [7:0] KMAP [16] = '{
        8'h01, 8'h02, 8'h03, 8'hF0,
        8'h04, 8'h05, 8'h06, 8'hF1,
        8'h07, 8'h08, 8'h09, 8'hF2,
        8'hC0, 8'h00, 8'hE0, 8'hF3
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys = '0;
    int          cyc;
    int          n_chk = 0;
    int          n_err = 0;
    int          n_rise = 0;
    int          n_exp = 0;
    bit          mon_en = 1'b0;
    bit          done = 1'b0;
    logic [7:0]  exp_q [$];

    keypad_scan_encoder_if kp_if ();

    keypad_scan_encoder #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp_if)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Keypad matrix: a closed key pulls its row low while its column is low.
    always_comb begin
        kp_if.row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !kp_if.col[c]) kp_if.row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, act, exp, $time, cyc);
        end
    endtask

    task automatic expect_key(input int idx);
        exp_q.push_back(KMAP[idx]);
        n_exp++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_cyc", cyc, n);
    endtask

    task automatic wait_pressed(input logic lvl, input int budget);
        int g = 0;
        while (kp_if.pressed !== lvl && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk("wait_pressed", kp_if.pressed, lvl);
    endtask

    task automatic wait_idle(input int budget);
        int g = 0;
        while (kp_if.key_code !== 8'hFF && g < budget) begin
            @(negedge clk);
            g++;
        end
        chk("wait_idle", kp_if.key_code, 8'hFF);
    endtask

    // Protocol monitor: code setup/hold around pressed, key_valid pulse,
    // one active column, release hold time and the expected-code scoreboard.
    task automatic monitor();
        logic       prev_pressed = 1'b0;
        logic [7:0] prev_code = 8'hFF;
        bit         fall_pend = 1'b0;
        int         fall_cyc = 0;
        while (!done) begin
            @(negedge clk);
            if (!rst || !mon_en) begin
                prev_pressed = 1'b0;
                prev_code    = 8'hFF;
                fall_pend    = 1'b0;
            end else begin
                chk("col_one_low", $countones(~kp_if.col), 1);
                if (kp_if.pressed && !prev_pressed) begin
                    n_rise++;
                    chk("kv_at_rise", kp_if.key_valid, 1'b1);
                    chk("code_setup", kp_if.key_code, prev_code);
                    if (exp_q.size() == 0) chk("sb_unexpected", exp_q.size(), 1);
                    else                   chk("sb_code", kp_if.key_code, exp_q.pop_front());
                end else if (kp_if.key_valid) begin
                    chk("kv_stray", kp_if.key_valid, 1'b0);
                end
                if (kp_if.pressed && prev_pressed) chk("code_hold", kp_if.key_code, prev_code);
                if (!kp_if.pressed && prev_pressed) begin
                    fall_pend = 1'b1;
                    fall_cyc  = cyc;
                end
                if (fall_pend && kp_if.key_code == 8'hFF && prev_code != 8'hFF) begin
                    chk("release_hold", cyc - fall_cyc, SCAN_DIV);
                    fall_pend = 1'b0;
                end
                prev_pressed = kp_if.pressed;
                prev_code    = kp_if.key_code;
            end
        end
    endtask

    // Press the given keys, hold, release and let the code return to idle.
    task automatic press_release(input logic [15:0] k, input int hold);
        keys = keys | k;
        wait_pressed(1'b1, 400);
        repeat (hold) @(negedge clk);
        keys = keys & ~k;
        wait_pressed(1'b0, 200);
        wait_idle(200);
    endtask

    task automatic main_seq();
        logic [3:0] ecol;
        int         bidx [3] = '{14, 3, 12};

        // Reset values while rst is held low.
        @(posedge clk);
        #1;
        chk("rst_col",       kp_if.col,       4'b1110);
        chk("rst_code",      kp_if.key_code,  8'hFF);
        chk("rst_pressed",   kp_if.pressed,   1'b0);
        chk("rst_key_valid", kp_if.key_valid, 1'b0);

        // Idle scan: column advances every SCAN_DIV clocks, nothing reported.
        do_reset();
        mon_en = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            wait_cyc(e);
            ecol = ~(4'b0001 << ((e / SCAN_DIV) % 4));
            chk("idle_col", kp_if.col, ecol);
            chk("idle_code", kp_if.key_code, 8'hFF);
            chk("idle_pressed", kp_if.pressed, 1'b0);
        end

        // Key "5" held from reset: column 1 is driven after edge 4, the rows
        // reach the sampler two clocks later, so the tick at edge 8 detects it.
        // Three more ticks (12, 16, 20) accept it; pressed follows at 21.
        keys = 16'h0020;
        expect_key(5);
        do_reset();
        wait_cyc(19);
        chk("lat5_code_pre", kp_if.key_code, 8'hFF);
        wait_cyc(20);
        chk("lat5_code", kp_if.key_code, 8'h05);
        chk("lat5_pressed_pre", kp_if.pressed, 1'b0);
        wait_cyc(21);
        chk("lat5_pressed", kp_if.pressed, 1'b1);
        chk("lat5_kv", kp_if.key_valid, 1'b1);
        wait_cyc(22);
        chk("lat5_kv_end", kp_if.key_valid, 1'b0);
        // Release after edge 44: high ticks at 48, 52, 56 -> pressed falls at 56,
        // code returns to FF one dwell later at 60.
        wait_cyc(44);
        keys = '0;
        wait_cyc(55);
        chk("rel5_pressed_pre", kp_if.pressed, 1'b1);
        wait_cyc(56);
        chk("rel5_pressed", kp_if.pressed, 1'b0);
        chk("rel5_code_hold", kp_if.key_code, 8'h05);
        wait_cyc(59);
        chk("rel5_code_late", kp_if.key_code, 8'h05);
        wait_cyc(60);
        chk("rel5_code_ff", kp_if.key_code, 8'hFF);

        // Bounced presses of "=", "+" and Clear: a short first contact,
        // a gap, then a stable press -- exactly one code each.
        foreach (bidx[i]) begin
            expect_key(bidx[i]);
            keys[bidx[i]] = 1'b1;
            repeat (2) @(negedge clk);
            keys[bidx[i]] = 1'b0;
            repeat (5) @(negedge clk);
            press_release(16'h0001 << bidx[i], 20);
        end

        // No rollover: "1" held, "9" added, only 01 while "1" is down;
        // after "1" is released the scan resumes and finds "9".
        expect_key(0);
        keys[0] = 1'b1;
        wait_pressed(1'b1, 400);
        keys[10] = 1'b1;
        repeat (30) @(negedge clk);
        chk("roll_pressed", kp_if.pressed, 1'b1);
        chk("roll_code", kp_if.key_code, 8'h01);
        expect_key(10);
        keys[0] = 1'b0;
        wait_pressed(1'b0, 200);
        wait_pressed(1'b1, 400);
        chk("roll_second", kp_if.key_code, 8'h09);
        keys[10] = 1'b0;
        wait_pressed(1'b0, 200);
        wait_idle(200);

        // Rows 0 and 2 low on column 0: lowest row wins.
        expect_key(0);
        press_release(16'h0101, 15);

        // Reset while held: outputs clear without a clock edge; afterwards the
        // still-held "1" needs a full fresh debounce (tick 4 detects, code at
        // edge 16, pressed at 17).
        expect_key(0);
        keys[0] = 1'b1;
        wait_pressed(1'b1, 400);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_pressed", kp_if.pressed, 1'b0);
        chk("arst_code", kp_if.key_code, 8'hFF);
        chk("arst_col", kp_if.col, 4'b1110);
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_key(0);
        #1 rst = 1'b1;
        wait_cyc(16);
        chk("arst_fresh_pre", kp_if.pressed, 1'b0);
        chk("arst_fresh_code", kp_if.key_code, 8'h01);
        wait_cyc(17);
        chk("arst_fresh_pressed", kp_if.pressed, 1'b1);
        keys[0] = 1'b0;
        wait_pressed(1'b0, 200);
        wait_idle(200);

        // Random presses, optional same-column second key, preceded by short
        // glitches that never last long enough to be seen at two ticks.
        for (int it = 0; it < 16; it++) begin
            int r1, r2, c, g;
            logic [15:0] k;
            g = $urandom_range(0, 15);
            keys[g] = 1'b1;
            repeat ($urandom_range(1, SCAN_DIV - 1)) @(negedge clk);
            keys[g] = 1'b0;
            repeat (3 * SCAN_DIV) @(negedge clk);
            r1 = $urandom_range(0, 3);
            c  = $urandom_range(0, 3);
            k  = 16'h0001 << (r1 * 4 + c);
            if ($urandom_range(0, 2) == 0) begin
                r2 = $urandom_range(0, 3);
                k  = k | (16'h0001 << (r2 * 4 + c));
                if (r2 < r1) r1 = r2;
            end
            expect_key(r1 * 4 + c);
            press_release(k, $urandom_range(5, 40));
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        chk("sb_empty", exp_q.size(), 0);
        chk("press_count", n_rise, n_exp);
        repeat (2) @(negedge clk);
        done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            main_seq();
        join
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
